// File: rtl/sign_mag_accum.sv
// Sign-magnitude block accumulator: sums LEN N-bit samples into an ACC_N-bit result.
// Optional macro SIGN_MAG_ACCUM_SAT_EN saturates the magnitude on overflow instead of wrapping.
module sign_mag_accum #(
  parameter int N     = 5,
  parameter int ACC_N = 8,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_N-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  localparam int CNT_W = (LEN > 2) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  typedef enum logic [0:0] {ACCUM = 1'b0, DONE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ACC_N-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ACC_N-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;
  logic [ACC_N:0]   step_s;

  // Returns {overflow, sum}; negative-zero operands behave as +0 and zero results are forced positive.
  function automatic logic [ACC_N:0] smadd(input logic [ACC_N-1:0] a, input logic [N-1:0] b);
    logic [ACC_N-2:0] ma;
    logic [ACC_N-2:0] mb;
    logic [ACC_N-1:0] wide;
    logic [ACC_N-2:0] mag;
    logic             sa;
    logic             sb;
    logic             sgn;
    logic             of;
    ma      = a[ACC_N-2:0];
    mb      = '0;
    mb[N-2:0] = b[N-2:0];
    sa      = a[ACC_N-1] && (ma != '0);
    sb      = b[N-1] && (mb != '0);
    wide    = '0;
    of      = 1'b0;
    if (sa == sb) begin
      wide = {1'b0, ma} + {1'b0, mb};
      sgn  = sa;
      of   = wide[ACC_N-1];
`ifdef SIGN_MAG_ACCUM_SAT_EN
      if (of) begin
        mag = '1;
      end else begin
        mag = wide[ACC_N-2:0];
      end
`else
      mag = wide[ACC_N-2:0];
`endif
    end else if (ma >= mb) begin
      mag = ma - mb;
      sgn = sa;
    end else begin
      mag = mb - ma;
      sgn = sb;
    end
    if (mag == '0) begin
      sgn = 1'b0;
    end else begin
      sgn = sgn;
    end
    return {of, sgn, mag};
  endfunction

  assign step_s    = smadd(acc_q, in_data);
  assign in_ready  = (state_q == ACCUM);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

  // Next-state and datapath for the accumulate / present cycle.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          acc_d   = step_s[ACC_N-1:0];
          count_d = count_q + CNT_W'(1);
          ovf_d   = ovf_q | step_s[ACC_N];
          if (count_q == LAST) begin
            out_data_d  = step_s[ACC_N-1:0];
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            out_valid_d = 1'b0;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_d       = '0;
          count_d     = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = ACCUM;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sign_mag_accum.sv
// Directed bench for sign_mag_accum: default build (ACC_N=8) plus a narrow ACC_N=6 copy for overflow.
module tb_sign_mag_accum;

  logic       clk;
  logic       reset;
  logic [4:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       ovf;

  logic [4:0] n_in_data;
  logic       n_in_valid;
  logic       n_in_ready;
  logic [5:0] n_out_data;
  logic       n_out_valid;
  logic       n_out_ready;
  logic       n_ovf;

  int n_checks;
  int n_errors;

  sign_mag_accum #(.N(5), .ACC_N(8), .LEN(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
  );

  sign_mag_accum #(.N(5), .ACC_N(6), .LEN(4)) dut6 (
    .clk(clk), .reset(reset), .in_data(n_in_data), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .out_data(n_out_data), .out_valid(n_out_valid), .out_ready(n_out_ready), .ovf(n_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send6(input logic [4:0] d);
    n_in_data  = d;
    n_in_valid = 1'b1;
    tick();
    n_in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    check_eq({tag, "_drained_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_drained_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  logic [5:0] exp6;

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    in_data     = 5'd0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    n_in_data   = 5'd0;
    n_in_valid  = 1'b0;
    n_out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", {24'd0, out_data}, 32'h00);
    check_eq("rst_ovf", {31'd0, ovf}, 32'd0);

    // 1: +1 x4
    for (int i = 0; i < 4; i++) send(5'b00001);
    check_eq("t1_valid", {31'd0, out_valid}, 32'd1);
    check_eq("t1_data", {24'd0, out_data}, 32'h04);
    check_eq("t1_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("t1_ovf", {31'd0, ovf}, 32'd0);
    drain("t1");

    // 2: -3 +1 +1 +1 gives positive zero
    send(5'b10011);
    check_eq("t2_partial_valid", {31'd0, out_valid}, 32'd0);
    send(5'b00001);
    send(5'b00001);
    send(5'b00001);
    check_eq("t2_data", {24'd0, out_data}, 32'h00);
    check_eq("t2_ovf", {31'd0, ovf}, 32'd0);
    drain("t2");

    // 3: -1 x4, then negative zero and +2 x3
    for (int i = 0; i < 4; i++) send(5'b10001);
    check_eq("t3a_data", {24'd0, out_data}, 32'h84);
    drain("t3a");
    send(5'b10000);
    for (int i = 0; i < 3; i++) send(5'b00010);
    check_eq("t3b_data", {24'd0, out_data}, 32'h06);
    drain("t3b");

    // 4: backpressure, samples presented in DONE must not be consumed
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(5'b00011);
    in_data  = 5'b00001;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      check_eq("t4_hold_data", {24'd0, out_data}, 32'h0C);
      check_eq("t4_hold_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check_eq("t4_released_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) send(5'b00001);
    check_eq("t4_next_data", {24'd0, out_data}, 32'h04);
    check_eq("t4_next_valid", {31'd0, out_valid}, 32'd1);
    drain("t4");

    // 5: ACC_N=6 overflow with +15 x4
`ifdef SIGN_MAG_ACCUM_SAT_EN
    exp6 = 6'b011111;
`else
    exp6 = 6'b011100;
`endif
    n_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send6(5'b01111);
    check_eq("t5_valid", {31'd0, n_out_valid}, 32'd1);
    check_eq("t5_data", {26'd0, n_out_data}, {26'd0, exp6});
    check_eq("t5_ovf", {31'd0, n_ovf}, 32'd1);
    n_out_ready = 1'b1;
    tick();
    check_eq("t5_ovf_cleared", {31'd0, n_ovf}, 32'd0);
    for (int i = 0; i < 4; i++) send6(5'b00001);
    check_eq("t5_next_data", {26'd0, n_out_data}, 32'h04);
    check_eq("t5_next_ovf", {31'd0, n_ovf}, 32'd0);
    tick();

    // 6: reset mid-block discards the partial sum
    send(5'b00001);
    send(5'b00001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("t6_rst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) send(5'b00001);
    check_eq("t6_data", {24'd0, out_data}, 32'h04);
    check_eq("t6_valid", {31'd0, out_valid}, 32'd1);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sign_mag_accum.md
Name: sign_mag_accum

Overview:
- Sequential block directly downstream of the sign_mag_add combinational adder.
- Consumes a stream of N-bit sign-magnitude words and accumulates LEN of them into a wider sign-magnitude sum.
- Presents the block result on a valid/ready output, then starts the next block.
- Uses the same add rules as sign_mag_add: same-sign adds magnitudes, opposite-sign subtracts the smaller from the larger.

Parameters:
N, 5, input word width including sign bit (MSB = sign, N-1 magnitude bits)
ACC_N, 8, accumulator/output width including sign bit; must satisfy ACC_N >= N
LEN, 4, samples per block; must satisfy LEN >= 2

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_data  input  N  sign-magnitude sample
in_valid  input  1  sample present
in_ready  output  1  block can accept a sample this cycle
out_data  output  ACC_N  sign-magnitude block sum
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
ovf  output  1  magnitude overflow occurred in this block; valid with out_valid

Behaviour:
- Reset values (synchronous, while reset=1 at the edge): state=ACCUM, acc=0, count=0, out_data=0, out_valid=0, ovf=0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-block discards the partial sum and count, and discards any pending output.
- States:
  - ACCUM: in_ready=1, out_valid=0. An input is accepted when in_valid&&in_ready.
    - Each accept updates acc on that edge: acc <= smadd(acc, in_data); count <= count+1.
    - The accept with count==LEN-1 also loads out_data <= smadd(acc, in_data), sets out_valid=1 and moves to DONE.
    - Latency: result visible the cycle after the last accept.
  - DONE: in_ready=0, out_valid=1. out_data and ovf are held stable; in_valid is ignored.
    - On out_valid&&out_ready: acc=0, count=0, ovf=0, out_valid=0, go to ACCUM.
    - No same-cycle accept of a new input in DONE (in_ready is 0).
- smadd rules (operand zero-extended on magnitude to ACC_N-1 bits):
  - Equal signs: mag = |a|+|b|; sign = common sign. Overflow if the carry exits ACC_N-1 bits.
  - Different signs: mag = larger minus smaller; sign = sign of the larger magnitude. Never overflows.
  - Equal magnitudes with different signs give mag 0.
  - Any zero result forces sign=0 (positive zero). Negative zero input (1_000..0) is treated as +0.
- ovf is sticky within a block: set on any overflowing step, cleared only on the output handshake or reset.
- in_ready is a pure function of state. No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Optional Feature:
- Macro SIGN_MAG_ACCUM_SAT_EN.
- Defined: on overflow, magnitude clamps to all-ones (2^(ACC_N-1)-1) and keeps the sign. Later steps continue from the clamped value. ovf is set.
- Undefined: on overflow, magnitude wraps modulo 2^(ACC_N-1). The zero-sign rule applies after the wrap. ovf is still set.

Test Plan:
1. Defaults; feed 00001 x4 back-to-back with out_ready=1 -> out_data=00000100, ovf=0, out_valid high exactly 1 cycle; in_ready=0 that cycle.
2. Feed 10011, 00001, 00001, 00001 (-3, +1, +1, +1) -> out_data=00000000 (positive zero, not 10000000), ovf=0.
3. Feed 10001 x4 -> out_data=10000100 (-4). Then 10000 (negative zero) plus 00010 x3 -> 00000110.
4. Backpressure: complete a block of 00011 x4 with out_ready=0 for 5 cycles, in_valid held 1 -> out_valid=1, out_data=00001100 stable, in_ready=0. No sample consumed until out_ready=1; next block starts from 0.
5. ACC_N=6; feed 01111 x4 (+60):
   - with SIGN_MAG_ACCUM_SAT_EN -> out_data=011111, ovf=1.
   - without -> out_data=011100 (60 mod 32 = 28), ovf=1.
6. Accept 2 samples of 00001, assert reset for 1 cycle -> out_valid=0, in_ready=1 after release. Then 00001 x4 -> out_data=00000100 (partial sum discarded).
